// File: rtl/alu_issue.sv
// Valid/ready sequencer for the combinational ALU: issues one operation, waits SETTLE cycles, captures the result.
// Optional illegal-op screening is enabled by defining ALU_ISSUE_OPCHK_EN.
module alu_issue #(
    parameter int WIDTH  = 16,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [3:0]       req_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ins,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [WIDTH-1:0] alu_hi,
    input  logic [2:0]       alu_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_out,
    output logic [WIDTH-1:0] rsp_hi,
    output logic [2:0]       rsp_flags,
    output logic             rsp_err
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt;
    logic       accept, capture, done, op_bad;

    if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
        $error("alu_issue: SETTLE=%0d outside legal range 1..15", SETTLE);
    end

`ifdef ALU_ISSUE_OPCHK_EN
    assign op_bad = (req_op == 4'd0) || (req_op > 4'd9);
`else
    assign op_bad = 1'b0;
`endif

    assign req_ready = (state == IDLE);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: if (req_valid) begin
                accept    = 1'b1;
                // screened ops skip the settle wait and answer at the accept edge
                state_nxt = op_bad ? RESP : WAIT;
            end
            WAIT: if (cnt == 4'd1) begin
                capture   = 1'b1;
                state_nxt = RESP;
            end
            RESP: if (rsp_ready) begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_ins   <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_out   <= '0;
            rsp_hi    <= '0;
            rsp_flags <= '0;
        end else begin
            state <= state_nxt;
            if (accept && !op_bad) begin
                alu_a   <= req_a;
                alu_b   <= req_b;
                alu_ins <= req_op;
                cnt     <= 4'(SETTLE);
            end
            if (accept && op_bad) begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b1;
                rsp_out   <= '0;
                rsp_hi    <= '0;
                rsp_flags <= '0;
            end
            if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (capture) begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b0;
                rsp_out   <= alu_out;
                rsp_hi    <= alu_hi;
                rsp_flags <= alu_flags;
            end
            if (done) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: two instances (SETTLE=1 and SETTLE=3) each driving a stub ALU,
// checked against a transaction-level model of expected results and latencies.
module tb_alu_issue;

    logic        clk;
    logic        rst_n;
    logic        req_valid[2], req_ready[2], rsp_valid[2], rsp_ready[2], rsp_err[2];
    logic [15:0] req_a[2], req_b[2], alu_a[2], alu_b[2], alu_out[2], alu_hi[2];
    logic [15:0] rsp_out[2], rsp_hi[2];
    logic [3:0]  req_op[2], alu_ins[2];
    logic [2:0]  alu_flags[2], rsp_flags[2];

    logic [15:0] last_a[2], last_b[2], exp_out[2], exp_hi[2];
    logic [3:0]  last_op[2];
    logic [2:0]  exp_flags[2];
    logic        exp_err[2];

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        alu_issue #(.WIDTH(16), .SETTLE(g == 0 ? 1 : 3)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_a     (req_a[g]),
            .req_b     (req_b[g]),
            .req_op    (req_op[g]),
            .alu_a     (alu_a[g]),
            .alu_b     (alu_b[g]),
            .alu_ins   (alu_ins[g]),
            .alu_out   (alu_out[g]),
            .alu_hi    (alu_hi[g]),
            .alu_flags (alu_flags[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_out   (rsp_out[g]),
            .rsp_hi    (rsp_hi[g]),
            .rsp_flags (rsp_flags[g]),
            .rsp_err   (rsp_err[g])
        );
        assign alu_out[g]   = alu_a[g] + alu_b[g] + 16'(alu_ins[g]);
        assign alu_hi[g]    = alu_a[g] - alu_b[g];
        assign alu_flags[g] = alu_ins[g][2:0];
    end

    function automatic int st(input int u);
        return (u == 0) ? 1 : 3;
    endfunction

    function automatic bit illegal(input logic [3:0] op);
        bit en;
`ifdef ALU_ISSUE_OPCHK_EN
        en = 1'b1;
`else
        en = 1'b0;
`endif
        return en && (op == 4'd0 || op > 4'd9);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            last_a[u]  = '0;
            last_b[u]  = '0;
            last_op[u] = '0;
        end
    endtask

    task automatic chk_zero(input int u, input string tag);
        chk({tag, "_alu_a"}, 32'(alu_a[u]), 0);
        chk({tag, "_alu_b"}, 32'(alu_b[u]), 0);
        chk({tag, "_alu_ins"}, 32'(alu_ins[u]), 0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid[u]), 0);
        chk({tag, "_rsp_err"}, 32'(rsp_err[u]), 0);
        chk({tag, "_rsp_out"}, 32'(rsp_out[u]), 0);
        chk({tag, "_rsp_hi"}, 32'(rsp_hi[u]), 0);
        chk({tag, "_rsp_flags"}, 32'(rsp_flags[u]), 0);
    endtask

    // Called at a negedge; returns at the negedge where the response is first visible.
    task automatic issue(input int u, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] op, output int acc);
        int n;
        bit bad;
        bad = illegal(op);
        req_a[u] = a;
        req_b[u] = b;
        req_op[u] = op;
        req_valid[u] = 1'b1;
        n = 0;
        while (!req_ready[u] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[u]) begin
            chk("accept_timeout", 32'(req_ready[u]), 1);
            req_valid[u] = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc + 1;
        @(posedge clk);
        @(negedge clk);
        req_valid[u] = 1'b0;
        if (!bad) begin
            last_a[u]  = a;
            last_b[u]  = b;
            last_op[u] = op;
        end
        chk("alu_a", 32'(alu_a[u]), 32'(last_a[u]));
        chk("alu_b", 32'(alu_b[u]), 32'(last_b[u]));
        chk("alu_ins", 32'(alu_ins[u]), 32'(last_op[u]));
        n = 0;
        while (!rsp_valid[u] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_valid_rise", 32'(rsp_valid[u]), 1);
        chk("latency", 32'(cyc - acc), bad ? 0 : 32'(st(u)));
        exp_out[u]   = bad ? 16'd0 : a + b + 16'(op);
        exp_hi[u]    = bad ? 16'd0 : a - b;
        exp_flags[u] = bad ? 3'd0 : op[2:0];
        exp_err[u]   = bad;
        chk("rsp_out", 32'(rsp_out[u]), 32'(exp_out[u]));
        chk("rsp_hi", 32'(rsp_hi[u]), 32'(exp_hi[u]));
        chk("rsp_flags", 32'(rsp_flags[u]), 32'(exp_flags[u]));
        chk("rsp_err", 32'(rsp_err[u]), 32'(exp_err[u]));
    endtask

    // Hold off the consumer for k cycles, then complete the handshake.
    task automatic hold(input int u, input int k);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid[u]), 1);
            chk("hold_out", 32'(rsp_out[u]), 32'(exp_out[u]));
            chk("hold_hi", 32'(rsp_hi[u]), 32'(exp_hi[u]));
            chk("hold_flags", 32'(rsp_flags[u]), 32'(exp_flags[u]));
            chk("hold_err", 32'(rsp_err[u]), 32'(exp_err[u]));
            chk("hold_req_ready", 32'(req_ready[u]), 0);
            chk("hold_alu_ins", 32'(alu_ins[u]), 32'(last_op[u]));
        end
        rsp_ready[u] = 1'b1;
        @(negedge clk);
        chk("hs_valid_low", 32'(rsp_valid[u]), 0);
        chk("hs_req_ready", 32'(req_ready[u]), 1);
    endtask

    initial begin
        int acc, prev, hs, k, u;
        logic [3:0] op;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_a[i] = '0;
            req_b[i] = '0;
            req_op[i] = '0;
            rsp_ready[i] = 1'b1;
        end
        model_reset();

        @(negedge clk);
        chk_zero(0, "por0");
        chk_zero(1, "por1");
        rst_n = 1'b1;
        @(negedge clk);
        chk("por_req_ready0", 32'(req_ready[0]), 1);
        chk("por_req_ready1", 32'(req_ready[1]), 1);

        // basic transaction, SETTLE=1
        issue(0, 16'd3, 16'd511, 4'd1, acc);
        chk("t2_out", 32'(rsp_out[0]), 515);
        chk("t2_hi", 32'(rsp_hi[0]), 32'h0000FE04);
        chk("t2_flags", 32'(rsp_flags[0]), 1);
        @(negedge clk);
        chk("t2_hs", 32'(rsp_valid[0]), 0);

        // backpressure with a pending request
        rsp_ready[0] = 1'b0;
        issue(0, 16'h1234, 16'h0F0F, 4'd5, acc);
        req_a[0] = 16'h00F0;
        req_b[0] = 16'h0003;
        req_op[0] = 4'd2;
        req_valid[0] = 1'b1;
        hold(0, 5);
        hs = cyc;
        issue(0, 16'h00F0, 16'h0003, 4'd2, acc);
        chk("t3_accept_edge", 32'(acc), 32'(hs + 1));
        @(negedge clk);

        // asynchronous reset in mid-cycle
        #2 rst_n = 1'b0;
        #1;
        chk_zero(0, "arst0");
        chk_zero(1, "arst1");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_req_ready", 32'(req_ready[0]), 1);

        // back-to-back sweep, SETTLE=3
        rsp_ready[1] = 1'b1;
        prev = 0;
        for (int i = 1; i <= 9; i++) begin
            issue(1, 16'd3, 16'd511, 4'(i), acc);
            chk("sweep_out", 32'(rsp_out[1]), 32'(514 + i));
            if (i > 1) chk("sweep_interval", 32'(acc - prev), 5);
            prev = acc;
        end
        @(negedge clk);

        // reset while the operation is settling
        req_a[1] = 16'hBEEF;
        req_b[1] = 16'h0101;
        req_op[1] = 4'd7;
        req_valid[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        chk("t5_in_wait", 32'(req_ready[1]), 0);
        #2 rst_n = 1'b0;
        #1;
        chk_zero(1, "t5rst");
        chk("t5_req_ready", 32'(req_ready[1]), 1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t5_no_rsp", 32'(rsp_valid[1]), 0);
        end
        issue(1, 16'h4000, 16'h0001, 4'd3, acc);
        @(negedge clk);

        // out-of-range op codes
        rsp_ready[0] = 1'b1;
        issue(0, 16'h00AA, 16'h0055, 4'd0, acc);
        @(negedge clk);
        issue(0, 16'h0101, 16'h0202, 4'd12, acc);
        @(negedge clk);

        // randomized traffic with random consumer stalls
        for (int i = 0; i < 12; i++) begin
            u = int'($urandom_range(0, 1));
            op = 4'($urandom_range(0, 15));
            k = int'($urandom_range(0, 3));
            rsp_ready[u] = 1'b0;
            issue(u, 16'($urandom), 16'($urandom), op, acc);
            hold(u, k);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
